// File: rtl/dice_pe_dyn_cfg_ctrl_if.sv
// rtl/dice_pe_dyn_cfg_ctrl_if.sv - dispatcher/PE-side bundle of the DICE PE dynamic-configuration controller
//
// master : dispatcher side, drives ld_*, iter_valid/iter_load and flush
// slave  : controller side, drives ld_ready, iter_ready, dff_*, iter_done, busy, fifo_count
interface dice_pe_dyn_cfg_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          iter_valid;
    logic          iter_ready;
    logic          iter_load;
    logic          flush;
    logic [31:0]   dff_in;
    logic          dff_input_mode;
    logic          dff_output_mode;
    logic          iter_done;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport master (
        output ld_valid, ld_data, iter_valid, iter_load, flush,
        input  ld_ready, iter_ready, dff_in, dff_input_mode, dff_output_mode,
               iter_done, busy, fifo_count
    );

    modport slave (
        input  ld_valid, ld_data, iter_valid, iter_load, flush,
        output ld_ready, iter_ready, dff_in, dff_input_mode, dff_output_mode,
               iter_done, busy, fifo_count
    );
endinterface

// File: rtl/dice_pe_dyn_cfg_ctrl.sv
// rtl/dice_pe_dyn_cfg_ctrl.sv - carry-in FIFO and iteration sequencer for one DICE PE column
//
// clk, rst_n : clock, synchronous active-low reset
// bus        : slave modport; carry-in push (ld_*), iteration request (iter_*),
//              flush, PE drive (dff_in, dff_input_mode, dff_output_mode),
//              status (iter_done, busy, fifo_count)
module dice_pe_dyn_cfg_ctrl #(
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dice_pe_dyn_cfg_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LD,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [31:0]      dff_in_q;
    logic             in_mode_q;
    logic             out_mode_q;
    logic             iter_done_q;

    logic fifo_empty;
    logic ld_ready_c;
    logic do_push;
    logic do_pop;

    // The pop decision looks only at the registered count, so a value pushed
    // this cycle cannot be consumed until the following edge.
    always_comb begin
        fifo_empty = (count == '0);
        ld_ready_c = (count < CW'(DEPTH));
        do_push    = bus.ld_valid && ld_ready_c;
        do_pop     = !fifo_empty &&
                     (((state == S_IDLE) && bus.iter_valid && bus.iter_load) ||
                      (state == S_WAIT_LD));
    end

    // Storage is not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (do_push && !bus.flush) begin
            mem[wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dff_in_q    <= '0;
            in_mode_q   <= 1'b0;
            out_mode_q  <= 1'b1;
            iter_done_q <= 1'b0;
        end else begin
            // The pulse follows the DONE cycle, so a flush seen while in DONE
            // cannot cancel it.
            iter_done_q <= (state == S_DONE);

            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= S_IDLE;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                // Entering LOAD: capture the head and toggle the input mode so
                // the PE latches dff_in.
                if (do_pop) begin
                    dff_in_q  <= mem[rd_ptr];
                    in_mode_q <= ~in_mode_q;
                    rd_ptr    <= rd_ptr + 1'b1;
                end
                count <= count + CW'(do_push) - CW'(do_pop);

                case (state)
                    S_IDLE: begin
                        if (bus.iter_valid) begin
                            if (!bus.iter_load) begin
                                state   <= S_RUN;
                                lat_cnt <= CNT_W'(PIPE_LAT - 1);
                            end else if (!fifo_empty) begin
                                state <= S_LOAD;
                            end else begin
                                state <= S_WAIT_LD;
                            end
                        end
                    end
                    S_WAIT_LD: begin
                        if (!fifo_empty) begin
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        // Point the output at the register that just captured.
                        out_mode_q <= ~in_mode_q;
                        state      <= S_RUN;
                        lat_cnt    <= CNT_W'(PIPE_LAT - 1);
                    end
                    S_RUN: begin
                        if (lat_cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            lat_cnt <= lat_cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ld_ready        = ld_ready_c;
    assign bus.iter_ready      = (state == S_IDLE);
    assign bus.busy            = (state != S_IDLE);
    assign bus.fifo_count      = count;
    assign bus.dff_in          = dff_in_q;
    assign bus.dff_input_mode  = in_mode_q;
    assign bus.dff_output_mode = out_mode_q;
    assign bus.iter_done       = iter_done_q;
endmodule

// File: tb/tb_dice_pe_dyn_cfg_ctrl.sv
// tb/tb_dice_pe_dyn_cfg_ctrl.sv - self-checking bench for dice_pe_dyn_cfg_ctrl
module tb_dice_pe_dyn_cfg_ctrl;
    localparam int DEPTH    = 4;
    localparam int PIPE_LAT = 3;

    logic clk;
    logic rst_n;

    dice_pe_dyn_cfg_ctrl_if #(.DEPTH(DEPTH)) bus ();

    dice_pe_dyn_cfg_ctrl #(
        .DEPTH   (DEPTH),
        .PIPE_LAT(PIPE_LAT),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a timeline of absolute edge numbers at which the
    // output-mode update and the done pulse are due.
    int          q[$];
    logic        m_in, m_out, m_done, m_active, m_wait;
    logic [31:0] m_dffin;
    logic        out_pend, done_pend;
    int          out_at, done_at, n_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    task automatic model_edge(input logic ldv, input logic [31:0] ldd, input logic itv,
                              input logic itl, input logic fl, input logic rn);
        int  pre;
        logic was_active, do_load;
        n_edge++;
        if (!rn) begin
            q.delete();
            m_in = 0; m_out = 1; m_dffin = 0; m_done = 0;
            m_active = 0; m_wait = 0; out_pend = 0; done_pend = 0;
            return;
        end
        pre        = q.size();
        was_active = m_active;
        m_done     = 0;
        if (done_pend && done_at == n_edge) begin
            m_done = 1; done_pend = 0; m_active = 0;
        end
        if (fl) begin
            q.delete();
            m_active = 0; m_wait = 0; out_pend = 0; done_pend = 0;
            return;
        end
        if (out_pend && out_at == n_edge) begin
            m_out = !m_in; out_pend = 0;
        end
        do_load = 0;
        if (!was_active && itv) begin
            m_active = 1;
            if (!itl) begin
                done_pend = 1; done_at = n_edge + PIPE_LAT + 1;
            end else if (pre > 0) begin
                do_load = 1;
            end else begin
                m_wait = 1;
            end
        end else if (m_wait && pre > 0) begin
            do_load = 1;
        end
        if (do_load) begin
            m_dffin   = q.pop_front();
            m_in      = !m_in;
            out_pend  = 1; out_at  = n_edge + 1;
            done_pend = 1; done_at = n_edge + PIPE_LAT + 2;
            m_wait    = 0;
        end
        if (ldv && pre < DEPTH) q.push_back(ldd);
    endtask

    task automatic check_model();
        chk("m_dff_in",     bus.dff_in,          m_dffin);
        chk("m_in_mode",    32'(bus.dff_input_mode),  32'(m_in));
        chk("m_out_mode",   32'(bus.dff_output_mode), 32'(m_out));
        chk("m_iter_done",  32'(bus.iter_done),  32'(m_done));
        chk("m_busy",       32'(bus.busy),       32'(m_active));
        chk("m_iter_ready", 32'(bus.iter_ready), 32'(!m_active));
        chk("m_fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("m_ld_ready",   32'(bus.ld_ready),   32'(q.size() < DEPTH));
    endtask

    task automatic step(input logic ldv, input logic [31:0] ldd, input logic itv,
                        input logic itl, input logic fl, input logic rn);
        bus.ld_valid   = ldv;
        bus.ld_data    = ldd;
        bus.iter_valid = itv;
        bus.iter_load  = itl;
        bus.flush      = fl;
        rst_n          = rn;
        @(posedge clk);
        model_edge(ldv, ldd, itv, itl, fl, rn);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_active && guard < 40) begin
            idle();
            guard++;
        end
        n_cmp++;
        if (m_active) begin
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles", guard);
        end
    endtask

    typedef struct {
        logic        ldv;
        logic [31:0] ldd;
        logic        itv;
        logic        itl;
        logic        fl;
        logic [31:0] e_dffin;
        logic        e_in;
        logic        e_out;
        logic        e_done;
        logic        e_busy;
        int          e_cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_valid = 0; bus.ld_data = 0; bus.iter_valid = 0;
        bus.iter_load = 0; bus.flush = 0; rst_n = 0;
        n_edge = 0;

        //              ldv ldd           itv itl fl  dff_in        in out done busy cnt
        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[9]  = '{1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1};

        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_dff_in",   bus.dff_in, 32'h0);
        chk("rst_in_mode",  32'(bus.dff_input_mode), 32'd0);
        chk("rst_out_mode", 32'(bus.dff_output_mode), 32'd1);
        chk("rst_done",     32'(bus.iter_done), 32'd0);
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_count",    32'(bus.fifo_count), 32'd0);

        // Loaded iteration (done at accept+5) then unloaded one (accept+4).
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].ldv, tbl[i].ldd, tbl[i].itv, tbl[i].itl, tbl[i].fl, 1);
            chk($sformatf("tbl%0d_dff_in", i),   bus.dff_in, tbl[i].e_dffin);
            chk($sformatf("tbl%0d_in_mode", i),  32'(bus.dff_input_mode),  32'(tbl[i].e_in));
            chk($sformatf("tbl%0d_out_mode", i), 32'(bus.dff_output_mode), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_done", i),     32'(bus.iter_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_busy", i),     32'(bus.busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_count", i),    32'(bus.fifo_count), 32'(tbl[i].e_cnt));
        end

        // Load requested with empty FIFO: wait, then capture on the edge after the push.
        do_reset();
        step(0, 0, 1, 1, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("wait_busy", 32'(bus.busy), 32'd1);
            chk("wait_in_mode", 32'(bus.dff_input_mode), 32'd0);
        end
        step(1, 32'h1234, 0, 0, 0, 1);
        chk("wait_push_no_toggle", 32'(bus.dff_input_mode), 32'd0);
        idle();
        chk("wait_toggle", 32'(bus.dff_input_mode), 32'd1);
        chk("wait_dff_in", bus.dff_in, 32'h1234);
        drain();
        idle();

        // Fill to DEPTH, overflow attempt dropped, then four loaded iterations.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0, 0, 1);
        chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        step(1, 32'd5, 0, 0, 0, 1);
        chk("full_drop_count", 32'(bus.fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 1, 0, 1);
            chk("seq_dff_in", bus.dff_in, 32'(k + 1));
            chk("seq_in_mode", 32'(bus.dff_input_mode), 32'((k % 2) == 0));
            drain();
        end
        chk("seq_count_empty", 32'(bus.fifo_count), 32'd0);

        // Flush during RUN with two values queued.
        do_reset();
        step(1, 32'h99, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        drain();
        step(1, 32'h11, 0, 0, 0, 1);
        step(1, 32'h22, 1, 0, 0, 1);
        idle();
        step(0, 0, 0, 0, 1, 1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_count", 32'(bus.fifo_count), 32'd0);
        chk("flush_in_mode", 32'(bus.dff_input_mode), 32'd1);
        chk("flush_out_mode", 32'(bus.dff_output_mode), 32'd0);
        chk("flush_dff_in", bus.dff_in, 32'h99);
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("flush_no_done", 32'(bus.iter_done), 32'd0);
        end

        // Reset while in LOAD, then a clean loaded iteration.
        step(1, 32'h77, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        do_reset();
        chk("rld_in_mode", 32'(bus.dff_input_mode), 32'd0);
        chk("rld_out_mode", 32'(bus.dff_output_mode), 32'd1);
        chk("rld_dff_in", bus.dff_in, 32'h0);
        chk("rld_count", 32'(bus.fifo_count), 32'd0);
        step(1, 32'hA5A5_0001, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        chk("rld2_dff_in", bus.dff_in, 32'hA5A5_0001);
        chk("rld2_in_mode", 32'(bus.dff_input_mode), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            idle();
            if (i == 1) chk("rld2_out_mode", 32'(bus.dff_output_mode), 32'd0);
            chk("rld2_done", 32'(bus.iter_done), 32'(i == 5));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 149) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
